friscv_rd_writeback: RTL

Writer side of the integer register file. It collects rd write-back requests from three producers (control unit, ALU, memory unit) over valid/ready handshakes and buffers each source in a small FIFO. A round-robin arbiter picks one request per cycle and drives the register file's single write port. It also keeps a per-register busy scoreboard, set by reservations from issue and cleared at write-back, which hazard detection queries.

---
 rtl/friscv_rd_writeback.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/friscv_rd_writeback.sv
// Integer register-file write-back: three buffered rd producers arbitrated round-robin
// onto the single register-file write port, plus the per-register busy scoreboard.
module friscv_rd_writeback #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            ctrl_valid,
    output logic            ctrl_ready,
    input  logic [4:0]      ctrl_addr,
    input  logic [XLEN-1:0] ctrl_data,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_addr,
    input  logic [XLEN-1:0] alu_data,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_addr,
    input  logic [XLEN-1:0] mem_data,
    input  logic            rsv_valid,
    output logic            rsv_ready,
    input  logic [4:0]      rsv_addr,
    input  logic [4:0]      chk_rs1_addr,
    output logic            chk_rs1_busy,
    input  logic [4:0]      chk_rs2_addr,
    output logic            chk_rs2_busy,
    output logic            rf_wr,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_val,
    output logic [31:0]     busy,
    output logic            idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Handshake: a transfer happens on an edge where valid && ready. ready only
    // reflects free FIFO space (and is low in reset); it never depends on valid.
    logic [2:0]      src_valid, src_ready, push, pop, empty, full;
    logic [4:0]      src_addr  [3];
    logic [XLEN-1:0] src_data  [3];
    logic [4:0]      head_addr [3];
    logic [XLEN-1:0] head_data [3];

    assign src_valid   = {mem_valid, alu_valid, ctrl_valid};
    assign src_addr[0] = ctrl_addr;
    assign src_addr[1] = alu_addr;
    assign src_addr[2] = mem_addr;
    assign src_data[0] = ctrl_data;
    assign src_data[1] = alu_data;
    assign src_data[2] = mem_data;
    assign ctrl_ready  = src_ready[0];
    assign alu_ready   = src_ready[1];
    assign mem_ready   = src_ready[2];

    for (genvar s = 0; s < 3; s++) begin : g_fifo
        logic [4:0]      slot_addr [FIFO_DEPTH];
        logic [XLEN-1:0] slot_data [FIFO_DEPTH];
        logic [AW:0]     wr_ptr, rd_ptr;

        assign empty[s]     = (wr_ptr == rd_ptr);
        assign full[s]      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign src_ready[s] = aresetn && !full[s];
        // x0 writes complete the handshake but are dropped here
        assign push[s]      = src_valid[s] && src_ready[s] && (src_addr[s] != 5'd0);
        assign head_addr[s] = slot_addr[rd_ptr[AW-1:0]];
        assign head_data[s] = slot_data[rd_ptr[AW-1:0]];

        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[s]) begin
                    slot_addr[wr_ptr[AW-1:0]] <= src_addr[s];
                    slot_data[wr_ptr[AW-1:0]] <= src_data[s];
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop[s]) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Round-robin: search starts at the source after the last grant (0 ctrl, 1 alu, 2 mem)
    logic [1:0]      last, gsel, cand;
    logic            found;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        found = 1'b0;
        gsel  = 2'd0;
        cand  = (last == 2'd2) ? 2'd0 : last + 2'd1;
        for (int k = 0; k < 3; k++) begin
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    assign pop = found ? (3'b001 << gsel) : 3'b000;

    always_comb begin
        case (gsel)
            2'd0:    begin sel_addr = head_addr[0]; sel_data = head_data[0]; end
            2'd1:    begin sel_addr = head_addr[1]; sel_data = head_data[1]; end
            default: begin sel_addr = head_addr[2]; sel_data = head_data[2]; end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last    <= 2'd2;
            rf_wr   <= 1'b0;
            rf_addr <= 5'd0;
            rf_val  <= '0;
        end else begin
            rf_wr <= found;
            if (found) begin
                last    <= gsel;
                rf_addr <= sel_addr;
                rf_val  <= sel_data;
            end
        end
    end

    // Clear lands one edge after rf_wr so the RF update and the clear appear together;
    // a reservation on the same edge wins over the clear.
    logic [31:0] busy_next;

    assign rsv_ready = aresetn && ((rsv_addr == 5'd0) || !busy[rsv_addr]);

    always_comb begin
        busy_next = busy;
        if (rf_wr) begin
            busy_next[rf_addr] = 1'b0;
        end
        if (rsv_valid && rsv_ready && (rsv_addr != 5'd0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign chk_rs1_busy = busy[chk_rs1_addr];
    assign chk_rs2_busy = busy[chk_rs2_addr];
    assign idle         = (&empty) && !rf_wr && (busy == 32'd0);

endmodule
